// File: rtl/zero_sync_gen.sv
// zero_sync_gen: turns the raw photo-interrupter zero pulse into a clean
// once-per-revolution event. The raw input is synchronised and debounced,
// rising edges of the filtered level are accepted as zero edges, and a small
// FSM tracks lock, measures the revolution period, decimates the zero flag
// and declares loss when edges stop arriving.
module zero_sync_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ZERO_DECIM      = 8,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zero_sig_in,
    input  logic        enable,
    output logic        zero_flag,
    output logic [31:0] zero_period,
    output logic        period_valid,
    output logic        zero_lost,
    output logic [15:0] rev_cnt
);

    localparam logic [15:0] DB_LAST      = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  DECIM_LAST   = 8'(ZERO_DECIM - 1);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        LOCK,
        LOST
    } state_t;

    // Input conditioning
    logic        sync1_q;
    logic        sync2_q;
    logic        filt_q;
    logic        filt_d;
    logic        filt_dly_q;
    logic        edge_q;
    logic [15:0] db_cnt_q;
    logic [15:0] db_cnt_d;

    // Revolution tracking
    state_t      state_q;
    logic [31:0] period_cnt_q;
    logic [31:0] period_cnt_inc;
    logic [7:0]  decim_cnt_q;
    logic [15:0] rev_cnt_q;
    logic [31:0] zero_period_q;
    logic        zero_flag_q;
    logic        period_valid_q;
    logic        zero_lost_q;
    logic        timeout_hit;
    logic        decim_wrap;

    // Debounce next state: count disagreeing cycles, adopt the new level
    // once DEBOUNCE_CYCLES of them have been seen back to back.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_LAST) begin
                filt_d   = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    // Synchroniser, debounce filter and registered rising-edge detect;
    // this path keeps running in every FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            edge_q     <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= zero_sig_in;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            db_cnt_q   <= db_cnt_d;
            filt_dly_q <= filt_q;
            edge_q     <= filt_q & ~filt_dly_q;
        end
    end

    // Period counter increment that saturates instead of wrapping, plus the
    // timeout and decimation terminal-count decodes.
    always_comb begin
        period_cnt_inc = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + 32'd1;
        timeout_hit    = (period_cnt_q == TIMEOUT_LAST);
        decim_wrap     = (decim_cnt_q == DECIM_LAST);
    end

    // Lock-tracking FSM with all outputs registered; disable overrides
    // everything and an accepted edge beats a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            period_cnt_q   <= '0;
            decim_cnt_q    <= '0;
            rev_cnt_q      <= '0;
            zero_period_q  <= '0;
            zero_flag_q    <= 1'b0;
            period_valid_q <= 1'b0;
            zero_lost_q    <= 1'b0;
        end else begin
            zero_flag_q    <= 1'b0;
            period_valid_q <= 1'b0;
            if (!enable) begin
                state_q       <= IDLE;
                period_cnt_q  <= '0;
                decim_cnt_q   <= '0;
                rev_cnt_q     <= '0;
                zero_period_q <= '0;
                zero_lost_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q       <= SEEK;
                        period_cnt_q  <= '0;
                        decim_cnt_q   <= '0;
                        rev_cnt_q     <= '0;
                        zero_period_q <= '0;
                        zero_lost_q   <= 1'b0;
                    end
                    SEEK, LOST: begin
                        if (edge_q) begin
                            state_q      <= LOCK;
                            zero_flag_q  <= 1'b1;
                            zero_lost_q  <= 1'b0;
                            decim_cnt_q  <= '0;
                            period_cnt_q <= '0;
                            rev_cnt_q    <= rev_cnt_q + 16'd1;
                        end else begin
                            period_cnt_q <= period_cnt_inc;
                        end
                    end
                    LOCK: begin
                        if (edge_q) begin
                            zero_period_q  <= period_cnt_q + 32'd1;
                            period_valid_q <= 1'b1;
                            period_cnt_q   <= '0;
                            rev_cnt_q      <= rev_cnt_q + 16'd1;
                            if (decim_wrap) begin
                                zero_flag_q <= 1'b1;
                                decim_cnt_q <= '0;
                            end else begin
                                decim_cnt_q <= decim_cnt_q + 8'd1;
                            end
                        end else begin
                            period_cnt_q <= period_cnt_inc;
                            if (timeout_hit) begin
                                state_q     <= LOST;
                                zero_lost_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign zero_flag    = zero_flag_q;
    assign zero_period  = zero_period_q;
    assign period_valid = period_valid_q;
    assign zero_lost    = zero_lost_q;
    assign rev_cnt      = rev_cnt_q;

endmodule

// File: tb/tb_zero_sync_gen.sv
// Bench for zero_sync_gen: directed stimulus on a DEBOUNCE=4 / DECIM=2 /
// TIMEOUT=100 instance checked every cycle against a timestamp-based model,
// plus a DEBOUNCE=1 / DECIM=1 instance driven through a full rev_cnt wrap.
`timescale 1ns/1ps
module tb_zero_sync_gen;

    localparam int D_CYC  = 4;
    localparam int ZD     = 2;
    localparam int T_CYC  = 100;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        raw   = 1'b0;
    logic        en    = 1'b0;
    logic        zero_flag, period_valid, zero_lost;
    logic [31:0] zero_period;
    logic [15:0] rev_cnt;

    logic        raw2 = 1'b0;
    logic        en2  = 1'b0;
    logic        zero_flag2, period_valid2, zero_lost2;
    logic [31:0] zero_period2;
    logic [15:0] rev_cnt2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    zero_sync_gen #(
        .DEBOUNCE_CYCLES(4),
        .ZERO_DECIM(2),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .zero_sig_in(raw), .enable(en),
        .zero_flag(zero_flag), .zero_period(zero_period),
        .period_valid(period_valid), .zero_lost(zero_lost), .rev_cnt(rev_cnt)
    );

    zero_sync_gen #(
        .DEBOUNCE_CYCLES(1),
        .ZERO_DECIM(1),
        .TIMEOUT_CYCLES(32'd100)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .zero_sig_in(raw2), .enable(en2),
        .zero_flag(zero_flag2), .zero_period(zero_period2),
        .period_valid(period_valid2), .zero_lost(zero_lost2), .rev_cnt(rev_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model (main instance) ----------------
    typedef enum {M_IDLE, M_SEEK, M_LOCK, M_LOST} mmode_t;
    mmode_t      m_mode = M_IDLE;
    bit          m_s1, m_s2, m_filt, m_rh0, m_rh1, m_acc, m_rose;
    int          m_run;
    longint      m_cyc, m_last_e;
    int          m_since_lock;
    bit          m_flag, m_pv, m_lost;
    logic [31:0] m_period = '0;
    logic [15:0] m_rev    = '0;

    task automatic model_step();
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_rh0 = 0; m_rh1 = 0; m_run = 0;
            m_cyc = 0; m_last_e = 0; m_since_lock = 0;
            m_flag = 0; m_pv = 0; m_lost = 0; m_period = '0; m_rev = '0;
        end else begin
            m_cyc++;
            m_rose = 0;
            if (m_s2 != m_filt) begin
                m_run++;
                if (m_run == D_CYC) begin
                    m_filt = m_s2;
                    m_run  = 0;
                    m_rose = m_filt;
                end
            end else begin
                m_run = 0;
            end
            // a filtered rise is acted upon two clocks later
            m_acc = m_rh1;
            m_rh1 = m_rh0;
            m_rh0 = m_rose;
            m_s2  = m_s1;
            m_s1  = raw;
            m_flag = 0;
            m_pv   = 0;
            if (!en) begin
                m_mode = M_IDLE; m_lost = 0; m_period = '0; m_rev = '0;
            end else begin
                case (m_mode)
                    M_IDLE: m_mode = M_SEEK;
                    M_SEEK, M_LOST: if (m_acc) begin
                        m_mode = M_LOCK; m_flag = 1; m_lost = 0; m_rev++;
                        m_last_e = m_cyc; m_since_lock = 0;
                    end
                    M_LOCK: if (m_acc) begin
                        m_period = 32'(m_cyc - m_last_e);
                        m_pv = 1; m_rev++; m_since_lock++;
                        m_flag = ((m_since_lock % ZD) == 0);
                        m_last_e = m_cyc;
                    end else if (m_cyc - m_last_e == longint'(T_CYC)) begin
                        m_mode = M_LOST; m_lost = 1;
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Every-cycle comparison of the main instance against the model
    initial forever begin
        @(negedge clk);
        check("model_flag", {31'd0, zero_flag}, {31'd0, m_flag});
        check("model_pv", {31'd0, period_valid}, {31'd0, m_pv});
        check("model_lost", {31'd0, zero_lost}, {31'd0, m_lost});
        check("model_period", zero_period, m_period);
        check("model_rev", {16'd0, rev_cnt}, {16'd0, m_rev});
    end

    // Wrap-instance monitor
    int unsigned w_flags = 0;
    bit          w_wrap_seen = 0, w_wrap_flag = 0;
    logic [15:0] w_prev = '0;
    initial forever begin
        @(negedge clk);
        if (zero_flag2) w_flags++;
        if (w_prev == 16'hFFFF && rev_cnt2 == 16'h0000) begin
            w_wrap_seen = 1;
            w_wrap_flag = zero_flag2;
        end
        w_prev = rev_cnt2;
    end

    // ---------------- directed stimulus ----------------
    int          fl, pv, lost_acc;
    logic [31:0] per;

    task automatic edge_window(input int len, input int hold);
        fl = 0; pv = 0; lost_acc = 0;
        raw = 1'b1;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            if (j == hold) raw = 1'b0;
            if (zero_flag) fl++;
            if (zero_lost) lost_acc++;
            if (period_valid) begin
                pv++;
                per = zero_period;
            end
        end
    endtask

    initial begin
        per = '0;
        tick(3);
        check("reset_flag", {31'd0, zero_flag}, 32'd0);
        check("reset_pv", {31'd0, period_valid}, 32'd0);
        check("reset_lost", {31'd0, zero_lost}, 32'd0);
        check("reset_period", zero_period, 32'd0);
        check("reset_rev", {16'd0, rev_cnt}, 32'd0);
        rst_n = 1'b1;

        // Latency: flag only after the 7th edge following the first high sample
        en = 1'b1;
        tick(4);
        raw = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("latency_flag", {31'd0, zero_flag}, (j == 7) ? 32'd1 : 32'd0);
            check("latency_pv", {31'd0, period_valid}, 32'd0);
        end
        check("latency_rev", {16'd0, rev_cnt}, 32'd1);
        raw = 1'b0;
        tick(12);

        // Decimation and period: 5 edges, 50 cycles apart
        en = 1'b0; tick(2); en = 1'b1; tick(3);
        for (int e = 1; e <= 5; e++) begin
            edge_window(50, 10);
            check("decim_flag", fl, (e % 2 == 1) ? 32'd1 : 32'd0);
            check("decim_pv", pv, (e > 1) ? 32'd1 : 32'd0);
            if (e > 1) check("decim_period", per, 32'd50);
        end
        check("decim_rev", {16'd0, rev_cnt}, 32'd5);

        // Glitch reject: 3-cycle pulses never become edges
        en = 1'b0; tick(2); en = 1'b1; tick(3);
        fl = 0;
        for (int j = 0; j < 60; j++) begin
            raw = (j < 45) && ((j % 9) < 3);
            @(negedge clk);
            if (zero_flag) fl++;
        end
        check("glitch_flag", fl, 32'd0);
        check("glitch_rev", {16'd0, rev_cnt}, 32'd0);
        edge_window(20, 10);
        check("glitch_seek_flag", fl, 32'd1);
        check("glitch_seek_pv", pv, 32'd0);

        // Timeout boundary
        en = 1'b0; tick(2); en = 1'b1; tick(3);
        edge_window(100, 10);
        fl = 0; pv = 0; lost_acc = 0;
        raw = 1'b1;
        for (int j = 0; j < 130; j++) begin
            @(negedge clk);
            if (j == 10) raw = 1'b0;
            if (period_valid) begin
                pv++;
                per = zero_period;
            end
            if (j == 50) check("tmo_lock_lost", {31'd0, zero_lost}, 32'd0);
            if (j == 106) check("tmo_before", {31'd0, zero_lost}, 32'd0);
            if (j == 107) check("tmo_after", {31'd0, zero_lost}, 32'd1);
        end
        check("tmo_pv", pv, 32'd1);
        check("tmo_period", per, 32'd100);
        check("tmo_lost_held", {31'd0, zero_lost}, 32'd1);
        edge_window(20, 10);
        check("relock_flag", fl, 32'd1);
        check("relock_pv", pv, 32'd0);
        check("relock_lost", {31'd0, zero_lost}, 32'd0);
        check("relock_period", zero_period, 32'd100);

        // Disable mid-run
        en = 1'b0; tick(2); en = 1'b1; tick(3);
        for (int e = 0; e < 3; e++) edge_window(30, 10);
        check("dis_rev_before", {16'd0, rev_cnt}, 32'd3);
        en = 1'b0;
        @(negedge clk);
        check("dis_flag", {31'd0, zero_flag}, 32'd0);
        check("dis_pv", {31'd0, period_valid}, 32'd0);
        check("dis_lost", {31'd0, zero_lost}, 32'd0);
        check("dis_period", zero_period, 32'd0);
        check("dis_rev", {16'd0, rev_cnt}, 32'd0);
        en = 1'b1; tick(3);
        edge_window(20, 10);
        check("reen_flag", fl, 32'd1);
        check("reen_rev", {16'd0, rev_cnt}, 32'd1);

        // Reset mid-period: outputs clear without a clock edge
        edge_window(30, 10);
        check("prerst_period", zero_period, 32'd20);
        tick(10);
        #1 rst_n = 1'b0;
        #1;
        check("arst_flag", {31'd0, zero_flag}, 32'd0);
        check("arst_lost", {31'd0, zero_lost}, 32'd0);
        check("arst_period", zero_period, 32'd0);
        check("arst_rev", {16'd0, rev_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        edge_window(20, 10);
        check("postrst_flag", fl, 32'd1);
        check("postrst_rev", {16'd0, rev_cnt}, 32'd1);

        // Wrap: 65536 edges on the DEBOUNCE=1 / DECIM=1 instance
        en = 1'b0;
        en2 = 1'b1;
        tick(3);
        for (int i = 0; i < 65536; i++) begin
            raw2 = 1'b1;
            @(negedge clk);
            raw2 = 1'b0;
            @(negedge clk);
        end
        tick(10);
        check("wrap_flags", w_flags, 32'd65536);
        check("wrap_rev", {16'd0, rev_cnt2}, 32'd0);
        check("wrap_seen", {31'd0, w_wrap_seen}, 32'd1);
        check("wrap_flag_at_wrap", {31'd0, w_wrap_flag}, 32'd1);
        check("wrap_lost", {31'd0, zero_lost2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zero_sync_gen.md
ZERO_SYNC_GEN -- requirements
Module: zero_sync_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before the filtered zero level changes (range 1..65535).
REQ-002 Parameter ZERO_DECIM, default 8: number of accepted zero edges per zero_flag pulse (range 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 32'd5_000_000: maximum cycles between zero edges before loss is declared (must be greater than 2).
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 zero_sig_in  input  1  raw photo-interrupter zero signal, active-high, asynchronous to clk.
REQ-007 enable  input  1  high = run; low = return to IDLE and clear all counters.
REQ-008 zero_flag  output  1  one-cycle pulse on every ZERO_DECIM-th accepted zero edge; feeds the distance averaging block.
REQ-009 zero_period  output  32  clock cycles between the two most recent consecutive edges in LOCK.
REQ-010 period_valid  output  1  one-cycle pulse coincident with each zero_period update.
REQ-011 zero_lost  output  1  level; high while in LOST.
REQ-012 rev_cnt  output  16  count of accepted zero edges; wraps from 65535 to 0.

Function
REQ-013 zero_sig_in shall pass a 2-flop synchronizer before any other use.
REQ-014 Debounce: a counter shall count consecutive cycles in which the synchronized value differs from the filtered level, clearing to 0 on any agreeing cycle.
REQ-015 When that counter reaches DEBOUNCE_CYCLES, the filtered level shall take the synchronized value and the counter shall clear.
REQ-016 An accepted edge is a registered 0->1 transition of the filtered level.
REQ-017 A raw rising held stable shall produce zero_flag (when due) exactly DEBOUNCE_CYCLES+3 clock edges after the first clock edge that samples zero_sig_in high.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no edge.
REQ-019 FSM states: IDLE, SEEK, LOCK, LOST.
REQ-020 IDLE -> SEEK when enable=1.
REQ-021 Any state -> IDLE when enable=0; in IDLE all counters are cleared and all outputs are 0.
REQ-022 SEEK -> LOCK on an accepted edge: zero_flag pulses, decim_cnt<=0, period_cnt<=0, rev_cnt increments, no period_valid.
REQ-023 In LOCK, an accepted edge shall:
  - set zero_period<=period_cnt+1 and pulse period_valid;
  - clear period_cnt to 0;
  - increment rev_cnt;
  - if decim_cnt==ZERO_DECIM-1, pulse zero_flag and set decim_cnt<=0, otherwise increment decim_cnt.
REQ-024 period_cnt shall increment every cycle in SEEK, LOCK and LOST, saturating at 32'hFFFF_FFFF.
REQ-025 LOCK -> LOST when period_cnt==TIMEOUT_CYCLES-1 and no accepted edge occurs that cycle; an edge in the same cycle wins and LOCK is kept.
REQ-026 SEEK performs no timeout.
REQ-027 LOST -> LOCK on an accepted edge, with the same actions as REQ-022; zero_period holds its last value.
REQ-028 zero_flag, period_valid and zero_lost shall be registered outputs.
REQ-029 ZERO_DECIM=1 shall flag every accepted edge.
REQ-030 Edges occurring in IDLE shall be ignored; the filter keeps running in IDLE.

Reset
REQ-031 rst_n low shall asynchronously force:
  - FSM to IDLE;
  - synchronizer, filtered level and every counter to 0;
  - zero_flag=0, period_valid=0, zero_lost=0, zero_period=0, rev_cnt=0.
REQ-032 Reset asserted mid-revolution shall discard all partial counts; after release the block re-enters SEEK and requires a fresh edge.

Verification (DEBOUNCE_CYCLES=4, ZERO_DECIM=2, TIMEOUT_CYCLES=100 unless stated)
REQ-033 Latency: enable=1, raise zero_sig_in at edge k and hold -> zero_flag high only at edge k+7, rev_cnt=1, no period_valid.
REQ-034 Decimation and period: zero rising edges exactly 50 cycles apart, 5 edges -> zero_flag on edges 1, 3, 5; period_valid on edges 2-5 with zero_period=50; rev_cnt=5.
REQ-035 Glitch reject: 3-cycle high pulses repeated -> no zero_flag, rev_cnt stays 0, state remains SEEK.
REQ-036 Timeout boundary:
  - edge, then next edge exactly 100 cycles later -> stays LOCK, zero_period=100;
  - edge, then 101 cycles with no edge -> zero_lost=1, state LOST;
  - next edge -> zero_lost=0, zero_flag pulses, zero_period unchanged.
REQ-037 Disable and reset mid-run: enable=0 after 3 edges -> next cycle all outputs 0; re-enable -> first edge flags.
REQ-038 Reset mid-run: assert rst_n mid-period -> outputs 0 immediately (asynchronously).
REQ-039 Wrap: force 65536 edges with ZERO_DECIM=1 -> rev_cnt wraps to 0 and zero_flag still pulses on every edge.
